stream_merge: RTL and testbench

- 2-to-1 AXI-Stream merger; the transmit-side counterpart of the tdest-based 1-to-2 stream switch.
- Combines two video line streams (camera channels 0/1) into one stream.
- Output beats are tagged with a per-source tdest (10'h2c0 / 10'h2c1) so the downstream switch can route them back.
- Arbitration is line-atomic (a grant is held until tlast), round-robin between sources, with one registered output stage and a runaway-line watchdog.

---
 rtl/stream_merge.sv | 182 ++++++++++++++++++
 tb/tb_stream_merge.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_merge.sv
// stream_merge: 2-to-1 AXI-Stream merger for two camera line streams.
// A grant is held for a whole line (until tlast) and alternates round-robin
// between the sources. Every output beat carries a per-source tdest so a
// downstream tdest switch can split the streams again. A watchdog cuts
// runaway lines at MAX_BEATS beats by forcing tlast and raising a sticky
// per-source error flag.
module stream_merge #(
  parameter int                     WIDTH       = 16,
  parameter int                     TUSER_WIDTH = 1,
  parameter int                     TDEST_WIDTH = 10,
  parameter logic [TDEST_WIDTH-1:0] TDEST0      = 10'h2c0,
  parameter logic [TDEST_WIDTH-1:0] TDEST1      = 10'h2c1,
  parameter logic [15:0]            MAX_BEATS   = 16'd4096
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s0_axis_tvalid,
  output logic                   s0_axis_tready,
  input  logic [WIDTH-1:0]       s0_axis_tdata,
  input  logic                   s0_axis_tlast,
  input  logic [TUSER_WIDTH-1:0] s0_axis_tuser,
  input  logic                   s1_axis_tvalid,
  output logic                   s1_axis_tready,
  input  logic [WIDTH-1:0]       s1_axis_tdata,
  input  logic                   s1_axis_tlast,
  input  logic [TUSER_WIDTH-1:0] s1_axis_tuser,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [WIDTH-1:0]       m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic [TDEST_WIDTH-1:0] m_axis_tdest,
  output logic [1:0]             err_overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t                 state_r;
  logic                   last_grant_r;
  logic [15:0]            beat_cnt_r;

  logic                   m_valid_r;
  logic [WIDTH-1:0]       m_data_r;
  logic                   m_last_r;
  logic [TUSER_WIDTH-1:0] m_user_r;
  logic [TDEST_WIDTH-1:0] m_dest_r;
  logic [1:0]             err_r;

  logic                   slot_free_s;
  logic                   s0_ready_s;
  logic                   s1_ready_s;
  logic                   accept_s;
  logic                   grant_idx_s;
  logic [WIDTH-1:0]       in_data_s;
  logic                   in_last_s;
  logic [TUSER_WIDTH-1:0] in_user_s;
  logic [TDEST_WIDTH-1:0] in_dest_s;
  logic                   force_last_s;
  logic                   end_line_s;

  // Source select: route the granted source to the output stage and gate readies.
  always_comb begin
    slot_free_s = !m_valid_r || m_axis_tready;
    s0_ready_s  = 1'b0;
    s1_ready_s  = 1'b0;
    accept_s    = 1'b0;
    grant_idx_s = 1'b0;
    in_data_s   = '0;
    in_last_s   = 1'b0;
    in_user_s   = '0;
    in_dest_s   = '0;
    case (state_r)
      GRANT0: begin
        s0_ready_s  = slot_free_s;
        accept_s    = s0_axis_tvalid && slot_free_s;
        grant_idx_s = 1'b0;
        in_data_s   = s0_axis_tdata;
        in_last_s   = s0_axis_tlast;
        in_user_s   = s0_axis_tuser;
        in_dest_s   = TDEST0;
      end
      GRANT1: begin
        s1_ready_s  = slot_free_s;
        accept_s    = s1_axis_tvalid && slot_free_s;
        grant_idx_s = 1'b1;
        in_data_s   = s1_axis_tdata;
        in_last_s   = s1_axis_tlast;
        in_user_s   = s1_axis_tuser;
        in_dest_s   = TDEST1;
      end
      default: begin
        s0_ready_s  = 1'b0;
        s1_ready_s  = 1'b0;
      end
    endcase
    // The MAX_BEATS-th beat of a line without tlast is cut by the watchdog.
    force_last_s = accept_s && !in_last_s && (beat_cnt_r == (MAX_BEATS - 16'd1));
    end_line_s   = accept_s && (in_last_s || force_last_s);
  end

  // Arbitration FSM: round-robin choice in IDLE, grant held until the line ends.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      beat_cnt_r   <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (s0_axis_tvalid && (!s1_axis_tvalid || last_grant_r)) begin
            state_r <= GRANT0;
          end else if (s1_axis_tvalid) begin
            state_r <= GRANT1;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT0, GRANT1: begin
          if (end_line_s) begin
            state_r      <= IDLE;
            last_grant_r <= grant_idx_s;
            beat_cnt_r   <= 16'd0;
          end else if (accept_s) begin
            beat_cnt_r   <= beat_cnt_r + 16'd1;
          end else begin
            beat_cnt_r   <= beat_cnt_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          beat_cnt_r <= 16'd0;
        end
      endcase
    end
  end

  // Output stage: capture accepted beats, hold while stalled, clear when drained.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
      m_last_r  <= 1'b0;
      m_user_r  <= '0;
      m_dest_r  <= '0;
    end else if (accept_s) begin
      m_valid_r <= 1'b1;
      m_data_r  <= in_data_s;
      m_last_r  <= in_last_s || force_last_s;
      m_user_r  <= in_user_s;
      m_dest_r  <= in_dest_s;
    end else if (m_axis_tready) begin
      m_valid_r <= 1'b0;
    end else begin
      m_valid_r <= m_valid_r;
    end
  end

  // Sticky overrun flags: set for the source whose line was cut by the watchdog.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_r <= 2'b00;
    end else if (force_last_s) begin
      err_r[grant_idx_s] <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign s0_axis_tready = s0_ready_s;
  assign s1_axis_tready = s1_ready_s;
  assign m_axis_tvalid  = m_valid_r;
  assign m_axis_tdata   = m_data_r;
  assign m_axis_tlast   = m_last_r;
  assign m_axis_tuser   = m_user_r;
  assign m_axis_tdest   = m_dest_r;
  assign err_overrun    = err_r;

endmodule

// File: tb/tb_stream_merge.sv
// Bench for stream_merge: a cycle table for a single line, hand-written
// sequences for arbitration, stall, watchdog and reset, and a randomized run
// checked by per-tdest scoreboards fed from a line-level reference model.
module tb_stream_merge;

  localparam int MAXB = 8;
  localparam int MEMN = 6200;

  logic        aclk;
  logic        aresetn;
  logic        s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
  logic [15:0] s0_axis_tdata;
  logic [0:0]  s0_axis_tuser;
  logic        s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
  logic [15:0] s1_axis_tdata;
  logic [0:0]  s1_axis_tuser;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [15:0] m_axis_tdata;
  logic [0:0]  m_axis_tuser;
  logic [9:0]  m_axis_tdest;
  logic [1:0]  err_overrun;

  stream_merge #(.MAX_BEATS(16'd8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tlast(s0_axis_tlast), .s0_axis_tuser(s0_axis_tuser),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tlast(s1_axis_tlast), .s1_axis_tuser(s1_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tdest(m_axis_tdest), .err_overrun(err_overrun)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [15:0] d;
    logic        u;
    logic        l;
  } beat_t;

  typedef struct {
    logic        s0v;
    logic [15:0] s0d;
    logic        s0u;
    logic        s0l;
    logic        mr;
    logic        e_mv;
    logic [15:0] e_md;
    logic        e_mu;
    logic        e_ml;
    logic        e_s0r;
    logic        e_s1r;
  } vec_t;

  int    total = 0;
  int    bad   = 0;
  beat_t src_mem [2][0:MEMN-1];
  int    src_len [2];
  int    src_idx [2];
  int    run_cnt [2];
  logic [1:0] exp_err;
  beat_t exp_q0[$];
  beat_t exp_q1[$];
  logic [9:0] line_dest_q[$];
  int    line_len_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    s0_axis_tvalid = 1'b0; s0_axis_tdata = 16'd0; s0_axis_tlast = 1'b0; s0_axis_tuser = 1'b0;
    s1_axis_tvalid = 1'b0; s1_axis_tdata = 16'd0; s1_axis_tlast = 1'b0; s1_axis_tuser = 1'b0;
    m_axis_tready  = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      src_len[k] = 0; src_idx[k] = 0; run_cnt[k] = 0;
    end
    exp_err = 2'b00;
    exp_q0.delete(); exp_q1.delete();
    line_dest_q.delete(); line_len_q.delete();
    @(negedge aclk);
    chk("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_m_data", 32'(m_axis_tdata), 32'd0);
    chk("rst_m_dest", 32'(m_axis_tdest), 32'd0);
    chk("rst_readys", 32'({s0_axis_tready, s1_axis_tready}), 32'd0);
    chk("rst_err", 32'(err_overrun), 32'd0);
    @(posedge aclk); #1;
  endtask

  // Append one line of len beats to source k; data is unique per source.
  task automatic gen_line(input int k, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = 16'((k * 32768) + src_len[k]);
      b.u = (i == 0) ? 1'b1 : 1'($urandom_range(1));
      b.l = (i == len - 1);
      src_mem[k][src_len[k]] = b;
      src_len[k]++;
    end
  endtask

  // Reference model: a line is cut after MAXB beats without tlast.
  task automatic model_accept(input int k, input beat_t b);
    beat_t e;
    logic  forced;
    run_cnt[k]++;
    forced = !b.l && (run_cnt[k] == MAXB);
    e.d = b.d; e.u = b.u; e.l = b.l || forced;
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    if (e.l) run_cnt[k] = 0;
    if (forced) exp_err[k] = 1'b1;
  endtask

  // Drive both sources from src_mem with AXI-legal valid, monitor the output.
  task automatic run_auto(input int pv, input int pr, input int stall_from,
                          input int stall_len, input int max_cyc);
    int          cyc, cur_len;
    logic        hs0, hs1, v0, v1, hold, in_line, done, have;
    beat_t       b0, b1, eb;
    logic [27:0] pl, prev_pl;
    logic [9:0]  cur_dest;
    cyc = 0; cur_len = 0; hs0 = 1'b0; hs1 = 1'b0; v0 = 1'b0; v1 = 1'b0;
    hold = 1'b0; in_line = 1'b0; done = 1'b0; b0 = '0; b1 = '0; eb = '0;
    prev_pl = '0; cur_dest = '0;
    while (!done && cyc < max_cyc) begin
      if (hs0) src_idx[0]++;
      if (hs1) src_idx[1]++;
      if (!v0 || hs0) begin
        v0 = (src_idx[0] < src_len[0]) && ($urandom_range(99) < pv);
        b0 = src_mem[0][src_idx[0]];
      end
      if (!v1 || hs1) begin
        v1 = (src_idx[1] < src_len[1]) && ($urandom_range(99) < pv);
        b1 = src_mem[1][src_idx[1]];
      end
      s0_axis_tvalid = v0; s0_axis_tdata = b0.d; s0_axis_tuser = b0.u; s0_axis_tlast = b0.l;
      s1_axis_tvalid = v1; s1_axis_tdata = b1.d; s1_axis_tuser = b1.u; s1_axis_tlast = b1.l;
      m_axis_tready = (cyc >= stall_from && cyc < stall_from + stall_len) ? 1'b0
                      : ($urandom_range(99) < pr);
      done = (src_idx[0] == src_len[0]) && (src_idx[1] == src_len[1]) &&
             (exp_q0.size() == 0) && (exp_q1.size() == 0) && !m_axis_tvalid;
      if (!done) begin
        @(negedge aclk);
        pl = {m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tdest};
        if (hold) begin
          chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
          chk("hold_payload", 32'(pl), 32'(prev_pl));
        end
        chk("one_ready", 32'(s0_axis_tready && s1_axis_tready), 32'd0);
        if (m_axis_tvalid && !m_axis_tready)
          chk("stall_readys", 32'({s0_axis_tready, s1_axis_tready}), 32'd0);
        if (m_axis_tvalid && m_axis_tready) begin
          chk("err_flags", 32'(err_overrun), 32'(exp_err));
          have = 1'b0;
          if (m_axis_tdest == 10'h2c0 && exp_q0.size() > 0) begin
            eb = exp_q0.pop_front(); have = 1'b1;
          end else if (m_axis_tdest == 10'h2c1 && exp_q1.size() > 0) begin
            eb = exp_q1.pop_front(); have = 1'b1;
          end
          chk("beat_expected", 32'(have), 32'd1);
          if (have) begin
            chk("beat_data", 32'(m_axis_tdata), 32'(eb.d));
            chk("beat_user", 32'(m_axis_tuser), 32'(eb.u));
            chk("beat_last", 32'(m_axis_tlast), 32'(eb.l));
          end
          if (in_line) begin
            chk("line_atomic", 32'(m_axis_tdest), 32'(cur_dest));
          end else begin
            in_line = 1'b1; cur_dest = m_axis_tdest; line_dest_q.push_back(m_axis_tdest);
          end
          cur_len++;
          if (m_axis_tlast) begin
            line_len_q.push_back(cur_len); cur_len = 0; in_line = 1'b0;
          end
        end
        hold = m_axis_tvalid && !m_axis_tready;
        prev_pl = pl;
        hs0 = s0_axis_tvalid && s0_axis_tready;
        hs1 = s1_axis_tvalid && s1_axis_tready;
        if (hs0) model_accept(0, b0);
        if (hs1) model_accept(1, b1);
        @(posedge aclk); #1;
        cyc++;
      end
    end
    chk("drain_in_budget", 32'(done), 32'd1);
    drive_idle();
  endtask

  function automatic vec_t mk(input logic s0v, input int s0d, input logic s0u, input logic s0l,
                              input logic mr, input logic e_mv, input int e_md, input logic e_mu,
                              input logic e_ml, input logic e_s0r, input logic e_s1r);
    vec_t v;
    v.s0v = s0v; v.s0d = 16'(s0d); v.s0u = s0u; v.s0l = s0l; v.mr = mr;
    v.e_mv = e_mv; v.e_md = 16'(e_md); v.e_mu = e_mu; v.e_ml = e_ml;
    v.e_s0r = e_s0r; v.e_s1r = e_s1r;
    return v;
  endfunction

  initial begin
    vec_t       tbl[7];
    logic [9:0] rr_exp[4];

    // One 4-beat line from s0: bubble cycle, then 1-cycle latency, tdest 2c0.
    tbl[0] = mk(1'b1, 1, 1'b1, 1'b0, 1'b1,  1'b0, 0, 1'b0, 1'b0,  1'b0, 1'b0);
    tbl[1] = mk(1'b1, 1, 1'b1, 1'b0, 1'b1,  1'b0, 0, 1'b0, 1'b0,  1'b1, 1'b0);
    tbl[2] = mk(1'b1, 2, 1'b0, 1'b0, 1'b1,  1'b1, 1, 1'b1, 1'b0,  1'b1, 1'b0);
    tbl[3] = mk(1'b1, 3, 1'b0, 1'b0, 1'b1,  1'b1, 2, 1'b0, 1'b0,  1'b1, 1'b0);
    tbl[4] = mk(1'b1, 4, 1'b0, 1'b1, 1'b1,  1'b1, 3, 1'b0, 1'b0,  1'b1, 1'b0);
    tbl[5] = mk(1'b0, 0, 1'b0, 1'b0, 1'b1,  1'b1, 4, 1'b0, 1'b1,  1'b0, 1'b0);
    tbl[6] = mk(1'b0, 0, 1'b0, 1'b0, 1'b1,  1'b0, 0, 1'b0, 1'b0,  1'b0, 1'b0);
    rr_exp[0] = 10'h2c0; rr_exp[1] = 10'h2c1; rr_exp[2] = 10'h2c0; rr_exp[3] = 10'h2c1;

    drive_idle();
    aresetn = 1'b0;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      s0_axis_tvalid = tbl[i].s0v; s0_axis_tdata = tbl[i].s0d;
      s0_axis_tuser  = tbl[i].s0u; s0_axis_tlast = tbl[i].s0l;
      m_axis_tready  = tbl[i].mr;
      @(negedge aclk);
      chk("tbl_m_valid", 32'(m_axis_tvalid), 32'(tbl[i].e_mv));
      chk("tbl_s0_ready", 32'(s0_axis_tready), 32'(tbl[i].e_s0r));
      chk("tbl_s1_ready", 32'(s1_axis_tready), 32'(tbl[i].e_s1r));
      if (tbl[i].e_mv) begin
        chk("tbl_m_data", 32'(m_axis_tdata), 32'(tbl[i].e_md));
        chk("tbl_m_user", 32'(m_axis_tuser), 32'(tbl[i].e_mu));
        chk("tbl_m_last", 32'(m_axis_tlast), 32'(tbl[i].e_ml));
        chk("tbl_m_dest", 32'(m_axis_tdest), 32'h2c0);
      end
      @(posedge aclk); #1;
    end
    drive_idle();

    // Both sources always valid, 3-beat lines: lines alternate s0,s1,s0,s1.
    do_reset();
    gen_line(0, 3); gen_line(0, 3);
    gen_line(1, 3); gen_line(1, 3);
    run_auto(100, 100, 1000000, 0, 200);
    chk("rr_line_count", 32'(line_dest_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (line_dest_q.size() > i) chk("rr_order", 32'(line_dest_q[i]), 32'(rr_exp[i]));

    // s1 line with a 5-cycle output stall in the middle.
    do_reset();
    gen_line(1, 6);
    run_auto(100, 100, 3, 5, 200);
    chk("stall_lines", 32'(line_len_q.size()), 32'd1);
    if (line_len_q.size() > 0) chk("stall_line_len", 32'(line_len_q[0]), 32'd6);

    // Watchdog: 10-beat s0 line is cut after beat 8, remainder is a new line.
    do_reset();
    gen_line(0, 10);
    run_auto(100, 100, 1000000, 0, 200);
    chk("wd_err", 32'(err_overrun), 32'd1);
    chk("wd_lines", 32'(line_len_q.size()), 32'd2);
    if (line_len_q.size() > 1) begin
      chk("wd_len0", 32'(line_len_q[0]), 32'd8);
      chk("wd_len1", 32'(line_len_q[1]), 32'd2);
      chk("wd_dest1", 32'(line_dest_q[1]), 32'h2c0);
    end

    // Reset in the middle of a GRANT1 line (err still set from the watchdog).
    s1_axis_tvalid = 1'b1; s1_axis_tdata = 16'h5000; s1_axis_tlast = 1'b0; s1_axis_tuser = 1'b1;
    m_axis_tready  = 1'b1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("mid_line_valid", 32'(m_axis_tvalid), 32'd1);
    chk("mid_line_dest", 32'(m_axis_tdest), 32'h2c1);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    s0_axis_tvalid = 1'b1; s0_axis_tdata = 16'h0100; s0_axis_tlast = 1'b0; s0_axis_tuser = 1'b0;
    @(negedge aclk);
    chk("mrst_m_valid", 32'(m_axis_tvalid), 32'd0);
    chk("mrst_readys", 32'({s0_axis_tready, s1_axis_tready}), 32'd0);
    chk("mrst_err", 32'(err_overrun), 32'd0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("mrst_s0_first", 32'({s0_axis_tready, s1_axis_tready}), 32'b10);

    // Random traffic on all three interfaces, ~10k beats, some runaway lines.
    do_reset();
    while (src_len[0] < 5000) gen_line(0, $urandom_range(12, 1));
    while (src_len[1] < 5000) gen_line(1, $urandom_range(12, 1));
    run_auto(70, 70, 1000000, 0, 60000);
    chk("rand_err", 32'(err_overrun), 32'(exp_err));
    chk("rand_q0_empty", 32'(exp_q0.size()), 32'd0);
    chk("rand_q1_empty", 32'(exp_q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
